// File: rtl/ar_cla_err_monitor.sv
// Error-characterisation monitor for the segmented dual-rail-carry CLA adder.
// Two-stage pipeline feeds windowed statistics presented through a valid/ready record.
module ar_cla_err_monitor #(
  parameter int   WIDTH   = 16,
  parameter int   WINDOW  = 256,
  parameter logic ACC_CTL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 cin,
  input  logic                 ctl,
  input  logic [WIDTH-1:0]     sum,
  input  logic [WIDTH/2-1:0]   cout,
  output logic                 stat_valid,
  input  logic                 stat_ready,
  output logic [15:0]          err_count,
  output logic [WIDTH:0]       max_ed,
  output logic [31:0]          sum_ed,
  output logic [15:0]          rail_err_count,
  output logic                 acc_err
);
  localparam int NP = WIDTH / 4;
  localparam int CW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      vld_pipe_q;
  logic            accept, clr;

  logic [WIDTH:0]  s1_exact_q, s1_approx_q;
  logic            s1_rail_q, s1_ctl_q;
  logic [WIDTH:0]  s2_ed_q;
  logic            s2_rail_q, s2_ctl_q;

  logic            rail_bad;
  logic [WIDTH:0]  ed;
  logic [32:0]     sum_ext;

  logic [15:0]     err_q, rail_q;
  logic [WIDTH:0]  max_q;
  logic [31:0]     sum_q;
  logic            acc_q;

  assign in_ready   = (state_q == ACCUM);
  assign stat_valid = (state_q == REPORT);
  assign accept     = in_valid && in_ready;

  always_comb begin
    rail_bad = 1'b0;
    for (int k = 0; k < NP; k++)
      if (cout[2*k+1] == cout[2*k]) rail_bad = 1'b1;
  end

  // Stage 1: exact reference sum and the adder's view of the same result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      s1_rail_q   <= 1'b0;
      s1_ctl_q    <= 1'b0;
      s2_ed_q     <= '0;
      s2_rail_q   <= 1'b0;
      s2_ctl_q    <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], accept};
      if (accept) begin
        s1_exact_q  <= {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
        s1_approx_q <= {cout[2*NP-1], sum};
        s1_rail_q   <= rail_bad;
        s1_ctl_q    <= ctl;
      end
      if (vld_pipe_q[0]) begin
        s2_ed_q   <= ed;
        s2_rail_q <= s1_rail_q;
        s2_ctl_q  <= s1_ctl_q;
      end
    end
  end

  always_comb begin
    if (s1_exact_q >= s1_approx_q) ed = s1_exact_q - s1_approx_q;
    else                           ed = s1_approx_q - s1_exact_q;
  end

  assign sum_ext = {1'b0, sum_q} + 33'(s2_ed_q);

  // Stage 2 accumulators; every counter sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= '0;
      rail_q <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      acc_q  <= 1'b0;
    end else if (clr) begin
      err_q  <= '0;
      rail_q <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      acc_q  <= 1'b0;
    end else if (vld_pipe_q[1]) begin
      if (s2_ed_q != '0 && err_q != '1) err_q <= err_q + 16'd1;
      if (s2_rail_q && rail_q != '1)    rail_q <= rail_q + 16'd1;
      if (s2_ed_q > max_q)              max_q <= s2_ed_q;
      sum_q <= sum_ext[32] ? '1 : sum_ext[31:0];
      if (s2_ed_q != '0 && s2_ctl_q == ACC_CTL) acc_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr)         cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + CW'(1);
    end
  end

  // DRAIN leaves once stage 1 is empty: stage 2 retires on that same edge
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      ACCUM:  if (accept && cnt_q == CW'(WINDOW - 1)) state_d = DRAIN;
      DRAIN:  if (!vld_pipe_q[0]) state_d = REPORT;
      REPORT: if (stat_ready) begin
        clr     = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign err_count      = err_q;
  assign rail_err_count = rail_q;
  assign max_ed         = max_q;
  assign sum_ed         = sum_q;
  assign acc_err        = acc_q;
endmodule

// File: tb/tb_ar_cla_err_monitor.sv
// Directed bench: WINDOW=4 instance checked against a scoreboard of per-window
// records; a WINDOW=70000 instance covers counter saturation.
module tb_ar_cla_err_monitor;
  logic        clk, rst;
  logic        in_valid, in_ready, in_valid2, in_ready2;
  logic [15:0] x, y, sum;
  logic        cin, ctl;
  logic [7:0]  cout;
  logic        stat_valid, stat_ready, stat_valid2, stat_ready2;
  logic [15:0] err_count, rail_err_count, err_count2, rail_err_count2;
  logic [16:0] max_ed, max_ed2;
  logic [31:0] sum_ed, sum_ed2;
  logic        acc_err, acc_err2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] err;
    logic [16:0] mx;
    logic [31:0] sm;
    logic [15:0] rail;
    logic        acc;
  } rec_t;

  rec_t exp_q[$];
  rec_t m;
  int   m_n;

  ar_cla_err_monitor #(.WIDTH(16), .WINDOW(4), .ACC_CTL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .ctl(ctl), .sum(sum), .cout(cout),
    .stat_valid(stat_valid), .stat_ready(stat_ready),
    .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed),
    .rail_err_count(rail_err_count), .acc_err(acc_err)
  );

  ar_cla_err_monitor #(.WIDTH(16), .WINDOW(70000), .ACC_CTL(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .x(x), .y(y), .cin(cin), .ctl(ctl), .sum(sum), .cout(cout),
    .stat_valid(stat_valid2), .stat_ready(stat_ready2),
    .err_count(err_count2), .max_ed(max_ed2), .sum_ed(sum_ed2),
    .rail_err_count(rail_err_count2), .acc_err(acc_err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.err = '0; m.mx = '0; m.sm = '0; m.rail = '0; m.acc = 1'b0;
    m_n = 0;
  endtask

  task automatic model_add(input logic [15:0] a, b, input logic ci, c,
                           input logic [15:0] s, input logic [7:0] co);
    logic [16:0] ex, ap, d;
    logic [32:0] t;
    logic        rb;
    ex = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    ap = {co[7], s};
    d  = (ex > ap) ? ex - ap : ap - ex;
    rb = 1'b0;
    for (int k = 0; k < 4; k++) if (co[2*k+1] == co[2*k]) rb = 1'b1;
    if (d != 0 && m.err != 16'hFFFF) m.err++;
    if (rb && m.rail != 16'hFFFF) m.rail++;
    if (d > m.mx) m.mx = d;
    t = {1'b0, m.sm} + {16'd0, d};
    m.sm = t[32] ? 32'hFFFF_FFFF : t[31:0];
    if (d != 0 && c) m.acc = 1'b1;
    m_n++;
    if (m_n == 4) begin
      exp_q.push_back(m);
      model_reset();
    end
  endtask

  // Presents one sample from a negedge and returns #1 after the accepting edge
  task automatic drive(input logic [15:0] a, b, input logic ci, c,
                       input logic [15:0] s, input logic [7:0] co);
    int w = 0;
    @(negedge clk);
    x = a; y = b; cin = ci; ctl = c; sum = s; cout = co; in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_add(a, b, ci, c, s, co);
  endtask

  // cyc = edges elapsed after the last accept when stat_valid is first seen
  task automatic wait_report(output int cyc, output logic rdy_first);
    cyc = 0;
    @(negedge clk);
    rdy_first = in_ready;
    while (!stat_valid && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("stat_valid_timeout", stat_valid, 1'b1);
  endtask

  task automatic check_report(input string tag);
    rec_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1'b0, 1'b1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_err_count"}, err_count, e.err);
    chk({tag, "_max_ed"}, max_ed, e.mx);
    chk({tag, "_sum_ed"}, sum_ed, e.sm);
    chk({tag, "_rail_err_count"}, rail_err_count, e.rail);
    chk({tag, "_acc_err"}, acc_err, e.acc);
  endtask

  task automatic handshake(input string tag);
    stat_ready = 1'b1;
    @(posedge clk);
    #1 stat_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_in_ready"}, in_ready, 1'b1);
    chk({tag, "_post_stat_valid"}, stat_valid, 1'b0);
    chk({tag, "_post_err_clear"}, err_count, 16'd0);
    chk({tag, "_post_sum_clear"}, sum_ed, 32'd0);
  endtask

  initial begin
    int   cyc, n;
    logic r0;
    rec_t snap;

    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    stat_ready = 1'b0; stat_ready2 = 1'b0;
    x = '0; y = '0; cin = 1'b0; ctl = 1'b0; sum = '0; cout = 8'h55;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stat_valid", stat_valid, 1'b0);
    chk("rst_err_count", err_count, 16'd0);
    chk("rst_acc_err", acc_err, 1'b0);
    rst = 1'b0;

    // Window of exact results
    repeat (4) drive(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 8'h55);
    wait_report(cyc, r0);
    chk("exact_in_ready_after_last", r0, 1'b0);
    chk("exact_report_latency", cyc, 2);
    check_report("exact");
    chk("exact_err_zero", err_count, 16'd0);
    handshake("exact");

    // Single approximate error in non-accurate mode
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h00F0, 8'h55);
    repeat (3) drive(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 8'h55);
    wait_report(cyc, r0);
    check_report("approx");
    chk("approx_max_ed_const", max_ed, 17'h10);
    chk("approx_err_const", err_count, 16'd1);
    handshake("approx");

    // Same error in accurate mode sets acc_err
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00F0, 8'h55);
    repeat (3) drive(16'h1234, 16'h0F0F, 1'b0, 1'b1, 16'h2143, 8'h55);
    wait_report(cyc, r0);
    check_report("acc");
    chk("acc_err_const", acc_err, 1'b1);
    handshake("acc");

    // Rail violations with correct sums, including top carry from cout[7]
    drive(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 8'h57);
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 8'hFF);
    drive(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 8'h55);
    drive(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 8'h55);
    wait_report(cyc, r0);
    check_report("rail");
    chk("rail_err_zero", err_count, 16'd0);
    handshake("rail");

    // Mixed errors, approx above and below exact, then held REPORT
    drive(16'h8000, 16'h8000, 1'b0, 1'b0, 16'hFFFF, 8'h55);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0010, 8'h55);
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00F0, 8'h5D);
    drive(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 8'h55);
    wait_report(cyc, r0);
    snap = exp_q[0];
    check_report("mixed");
    x = 16'h0001; y = 16'h0002; cin = 1'b0; ctl = 1'b0; sum = 16'h0007; cout = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stat_valid", stat_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_sum_ed", sum_ed, snap.sm);
      chk("hold_max_ed", max_ed, snap.mx);
    end
    stat_ready = 1'b1;
    @(posedge clk);
    #1 stat_ready = 1'b0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_err_clear", err_count, 16'd0);
    chk("release_stat_valid", stat_valid, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_add(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0007, 8'h55);
    stat_ready = 1'b1;
    repeat (2) @(negedge clk);
    stat_ready = 1'b0;
    repeat (3) drive(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0200, 8'h55);
    wait_report(cyc, r0);
    check_report("held");
    handshake("held");

    // Async reset with two samples in flight
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00F0, 8'h57);
    repeat (3) @(negedge clk);
    chk("pre_rst_err", err_count, 16'd1);
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00F0, 8'h57);
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00F0, 8'h57);
    #1 rst = 1'b1;
    #1;
    chk("arst_err_count", err_count, 16'd0);
    chk("arst_sum_ed", sum_ed, 32'd0);
    chk("arst_max_ed", max_ed, 17'd0);
    chk("arst_rail", rail_err_count, 16'd0);
    chk("arst_acc_err", acc_err, 1'b0);
    chk("arst_stat_valid", stat_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0F00, 16'h00F0, 1'b1, 1'b0, 16'h0FF0, 8'h55);
    repeat (3) drive(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 8'h55);
    wait_report(cyc, r0);
    chk("fresh_report_latency", cyc, 2);
    check_report("fresh");
    handshake("fresh");

    // Saturation: 70000 samples, each erroneous with a bad rail pair
    x = 16'h00FF; y = 16'h0001; cin = 1'b0; ctl = 1'b0; sum = 16'h00F0; cout = 8'h57;
    @(negedge clk);
    in_valid2 = 1'b1;
    n = 0;
    while (!stat_valid2 && n < 70100) begin
      @(negedge clk);
      n++;
    end
    in_valid2 = 1'b0;
    chk("sat_stat_valid", stat_valid2, 1'b1);
    chk("sat_err_count", err_count2, 16'hFFFF);
    chk("sat_rail_count", rail_err_count2, 16'hFFFF);
    chk("sat_sum_ed", sum_ed2, 32'd1120000);
    chk("sat_max_ed", max_ed2, 17'h10);
    chk("sat_acc_err", acc_err2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
